nand_flash_ctrl_mp: RTL

NAND_FLASH_CTRL_MP -- requirements
Module: nand_flash_ctrl_mp

---
 rtl/nand_flash_ctrl_mp_pkg.sv | 29 ++
 rtl/nand_flash_ctrl_mp_timeout_ctr.sv | 28 ++
 rtl/nand_flash_ctrl_mp.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nand_flash_ctrl_mp_pkg.sv
// Shared definitions for the multi-page NAND flash controller:
// FSM state encoding, host command codes and default parameter values.
package nfc_pkg;

    localparam int NFC_ADDR_W     = 16;
    localparam int NFC_DATA_W     = 16;
    localparam int NFC_CMD_W      = 3;
    localparam int NFC_PAGE_WORDS = 8;
    localparam int NFC_MAX_PAGES  = 4;
    localparam int NFC_TIMEOUT    = 1024;

    localparam int CMD_ERASE   = 0;
    localparam int CMD_PROGRAM = 1;
    localparam int CMD_READ    = 2;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_CMD        = 4'd1,
        ST_ADDR       = 4'd2,
        ST_PROG_DATA  = 4'd3,
        ST_PROG_WAIT  = 4'd4,
        ST_READ_WAIT  = 4'd5,
        ST_READ_DATA  = 4'd6,
        ST_ERASE_WAIT = 4'd7,
        ST_NEXT_PAGE  = 4'd8,
        ST_FINISH     = 4'd9
    } nfc_state_e;

endpackage

// File: rtl/nand_flash_ctrl_mp_timeout_ctr.sv
// Status-wait watchdog: counts enabled cycles from a clear and flags
// the cycle on which the count reaches TIMEOUT-1.
module nfc_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Count wait cycles; hold at the terminal value so expired stays stable.
    always_ff @(posedge clk) begin
        if (Reset || clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/nand_flash_ctrl_mp.sv
// Multi-page NAND flash controller: erase, program burst and read burst
// with a per-wait timeout, buffer handshakes and sticky error flags.
module nand_flash_ctrl_mp
    import nfc_pkg::*;
#(
    parameter int ADDR_W     = NFC_ADDR_W,
    parameter int DATA_W     = NFC_DATA_W,
    parameter int CMD_W      = NFC_CMD_W,
    parameter int PAGE_WORDS = NFC_PAGE_WORDS,
    parameter int MAX_PAGES  = NFC_MAX_PAGES,
    parameter int TIMEOUT    = NFC_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           nfc_start,
    input  logic [CMD_W-1:0]               nfc_cmd,
    input  logic [ADDR_W-1:0]              RWA,
    input  logic [$clog2(MAX_PAGES+1)-1:0] page_cnt,
    output logic                           nfc_busy,
    output logic                           nfc_done,
    output logic                           command_error,
    output logic                           timeout_error,
    output logic                           cEn,
    output logic                           CLE,
    output logic                           ALE,
    output logic                           wEn,
    output logic                           rEn,
    output logic [DATA_W-1:0]              dio_out,
    output logic                           dio_oe,
    input  logic [DATA_W-1:0]              dio_in,
    input  logic                           status,
    input  logic                           buf_rd_valid,
    input  logic [DATA_W-1:0]              buf_rd_data,
    output logic                           buf_rd_ready,
    output logic                           buf_wr_valid,
    output logic [DATA_W-1:0]              buf_wr_data,
    input  logic                           buf_wr_ready
);

    localparam int PCNT_W = $clog2(MAX_PAGES + 1);
    localparam int WCNT_W = $clog2(PAGE_WORDS + 1);

    nfc_state_e        state, state_nxt;
    logic [CMD_W-1:0]  cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PCNT_W-1:0] pages_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              done_q, cmd_err_q, tmo_err_q;

    logic start_ok, in_wait, expired, timeout_fire;
    logic wr_beat, rd_beat, last_word;

    // Erase ignores page_cnt; bursts need 1..MAX_PAGES pages.
    assign start_ok = (nfc_cmd == CMD_W'(CMD_ERASE)) ||
                      (((nfc_cmd == CMD_W'(CMD_PROGRAM)) || (nfc_cmd == CMD_W'(CMD_READ))) &&
                       (page_cnt != '0) && (page_cnt <= PCNT_W'(MAX_PAGES)));

    assign in_wait      = (state == ST_ERASE_WAIT) || (state == ST_PROG_WAIT) ||
                          (state == ST_READ_WAIT);
    // A ready status in the same cycle as expiry takes priority over the timeout.
    assign timeout_fire = in_wait && !status && expired;
    assign wr_beat      = (state == ST_PROG_DATA) && buf_rd_valid;
    assign rd_beat      = (state == ST_READ_DATA) && buf_wr_ready;
    assign last_word    = (wcnt_q == WCNT_W'(PAGE_WORDS - 1));

    // Counter is held clear outside wait states so every wait starts at zero.
    nfc_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .Reset   (Reset),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (expired)
    );

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (nfc_start && start_ok) state_nxt = ST_CMD;
            ST_CMD:        state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (cmd_q == CMD_W'(CMD_ERASE))        state_nxt = ST_ERASE_WAIT;
                else if (cmd_q == CMD_W'(CMD_PROGRAM)) state_nxt = ST_PROG_DATA;
                else                                   state_nxt = ST_READ_WAIT;
            end
            ST_PROG_DATA:  if (wr_beat && last_word) state_nxt = ST_PROG_WAIT;
            ST_PROG_WAIT:  if (status) state_nxt = ST_NEXT_PAGE;
                           else if (expired) state_nxt = ST_IDLE;
            ST_READ_WAIT:  if (status) state_nxt = ST_READ_DATA;
                           else if (expired) state_nxt = ST_IDLE;
            ST_ERASE_WAIT: if (status) state_nxt = ST_FINISH;
                           else if (expired) state_nxt = ST_IDLE;
            ST_READ_DATA:  if (rd_beat && last_word) state_nxt = ST_NEXT_PAGE;
            ST_NEXT_PAGE:  state_nxt = (pages_q > PCNT_W'(1)) ? ST_CMD : ST_FINISH;
            ST_FINISH:     state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // State, latched request fields, word/page bookkeeping and status flags.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            addr_q    <= '0;
            pages_q   <= '0;
            wcnt_q    <= '0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            if (state == ST_IDLE && nfc_start) begin
                cmd_q     <= nfc_cmd;
                addr_q    <= RWA;
                pages_q   <= page_cnt;
                cmd_err_q <= !start_ok;
                tmo_err_q <= 1'b0;
                done_q    <= !start_ok;
            end
            if (timeout_fire) begin
                tmo_err_q <= 1'b1;
                done_q    <= 1'b1;
            end
            if (state == ST_NEXT_PAGE) begin
                pages_q <= pages_q - 1'b1;
                addr_q  <= addr_q + 1'b1;
            end
            if (wr_beat || rd_beat) begin
                wcnt_q <= last_word ? '0 : wcnt_q + 1'b1;
            end
        end
    end

    // Flash strobes and buffer handshakes decoded from the current state.
    always_comb begin
        CLE          = 1'b0;
        ALE          = 1'b0;
        wEn          = 1'b0;
        rEn          = 1'b0;
        dio_oe       = 1'b0;
        dio_out      = '0;
        buf_rd_ready = 1'b0;
        buf_wr_valid = 1'b0;
        buf_wr_data  = '0;
        case (state)
            ST_CMD: begin
                CLE     = 1'b1;
                dio_oe  = 1'b1;
                dio_out = DATA_W'(cmd_q);
            end
            ST_ADDR: begin
                ALE     = 1'b1;
                dio_oe  = 1'b1;
                dio_out = DATA_W'(addr_q);
            end
            ST_PROG_DATA: begin
                buf_rd_ready = 1'b1;
                if (buf_rd_valid) begin
                    wEn     = 1'b1;
                    dio_oe  = 1'b1;
                    dio_out = buf_rd_data;
                end
            end
            ST_READ_DATA: begin
                if (buf_wr_ready) begin
                    rEn          = 1'b1;
                    buf_wr_valid = 1'b1;
                    buf_wr_data  = dio_in;
                end
            end
            default: ;
        endcase
    end

    assign cEn           = (state != ST_IDLE);
    assign nfc_busy      = (state != ST_IDLE);
    assign nfc_done      = done_q || (state == ST_FINISH);
    assign command_error = cmd_err_q;
    assign timeout_error = tmo_err_q;

endmodule
